color_sense_ctrl: RTL
=====================

COLOR_SENSE_CTRL -- requirements
Module: color_sense_ctrl

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000, clk cycles per colour measurement window (1 ms at 50 MHz).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 64, clk cycles discarded after each filter change.
REQ-003 SHALL have parameter CNT_W, default 16, width of each colour count.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a four-channel frame.
REQ-007 in_sq  in  1  asynchronous square wave from the colour sensor; frequency is proportional to intensity.
REQ-008 s_ctrl  out  2  sensor filter select (S2,S3).
REQ-009 get_it  out  1  one-cycle pulse: a new frame is available.
REQ-010 busy  out  1  high while a frame is in progress.
REQ-011 red, green, blue, clear  out  CNT_W each  last completed frame counts.
REQ-012 sat  out  1  at least one channel of the last completed frame saturated.

Function
REQ-013 in_sq SHALL pass through a 2-flop synchroniser, then a rising-edge detector; an edge is one synchronised 0->1 transition, 3-cycle input-to-detect latency.
REQ-014 s_ctrl encoding SHALL be red=00, blue=01, clear=10, green=11.
REQ-015 Channel order within a frame SHALL be red, green, blue, clear.
REQ-016 States: IDLE, SETTLE, GATE, STORE, DONE.
REQ-017 IDLE: busy=0; start=1 -> SETTLE for red, s_ctrl=00 from the next cycle.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles; edges detected during SETTLE SHALL be ignored; working counter cleared on entry.
REQ-019 GATE SHALL last exactly GATE_CYCLES cycles; each detected edge increments the working counter, including an edge on the final GATE cycle.
REQ-020 Working counter SHALL saturate at 2^CNT_W-1 and never wrap; saturation sets a frame-local sat flag.
REQ-021 STORE SHALL last 1 cycle, latching the working count into the channel shadow register, then go to SETTLE for the next channel with s_ctrl updated, or to DONE after clear.
REQ-022 DONE SHALL last 1 cycle: copy all four shadows and the frame sat flag to the outputs simultaneously, assert get_it, return to IDLE.
REQ-023 Outputs red/green/blue/clear/sat SHALL change only in the DONE cycle; partial frames SHALL never be visible.
REQ-024 start-accept to get_it latency SHALL be exactly 4*(SETTLE_CYCLES+GATE_CYCLES+1)+1 cycles.
REQ-025 start while busy=1 SHALL be ignored, not queued.
REQ-026 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-027 busy SHALL be 1 in SETTLE, GATE, STORE and DONE.
REQ-028 s_ctrl SHALL hold its value from the end of a frame until the next frame's red select.

Reset
REQ-029 While reset=1: state=IDLE, s_ctrl=00, get_it=0, busy=0, all counts and shadows 0, sat=0, synchroniser flops 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no get_it pulse; outputs return to reset values.
REQ-031 start coincident with reset SHALL be ignored.

Verification (SETTLE_CYCLES=4, GATE_CYCLES=100, CNT_W=8)
REQ-032 in_sq period 10 cycles, start pulse -> get_it exactly 421 cycles later; red=green=blue=clear=10 (+/-1); sat=0.
REQ-033 in_sq toggling every cycle (period 2), start -> each channel=50, sat=0; with CNT_W=4 each channel=15 and sat=1.
REQ-034 Distinct per-filter frequencies keyed off s_ctrl (00->period 4, 11->period 10, 01->period 20, 10->period 50) -> red=25, green=10, blue=5, clear=2 (+/-1).
REQ-035 Second start 50 cycles after the first -> ignored; exactly one get_it; busy stays 1 throughout.
REQ-036 reset pulse 200 cycles into a frame -> no get_it, all outputs 0, s_ctrl=00; a fresh start completes normally after 421 cycles.
REQ-037 in_sq edges only during SETTLE windows (gated by the bench) -> all channels=0, get_it still at 421 cycles.

Source files
------------

// File: rtl/color_sense_ctrl.sv
// Colour-sensor frame controller: walks the filter through red, green, blue, clear,
// counts sensor edges in a fixed gate window per channel and publishes whole frames only.
module color_sense_ctrl #(
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_sq,
  output logic [1:0]       s_ctrl,
  output logic             get_it,
  output logic             busy,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] green,
  output logic [CNT_W-1:0] blue,
  output logic [CNT_W-1:0] clear,
  output logic             sat
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, STORE, DONE} state_t;

  // Channel index 0..3 is frame order red, green, blue, clear.
  function automatic logic [1:0] filter_sel(input logic [1:0] ch);
    case (ch)
      2'd0:    filter_sel = 2'b00;
      2'd1:    filter_sel = 2'b11;
      2'd2:    filter_sel = 2'b01;
      default: filter_sel = 2'b10;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [1:0]              ch_q, ch_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    fsat_q, fsat_d;
  logic [2:0][CNT_W-1:0]   sh_q, sh_d;
  logic [1:0]              sel_q, sel_d;
  logic [CNT_W-1:0]        red_q, red_d, green_q, green_d, blue_q, blue_d, clear_q, clear_d;
  logic                    sat_q, sat_d;
  logic [2:0]              sync_q;
  logic                    edge_q;

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path infers a latch.
    state_d = state_q;
    tmr_d   = tmr_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    fsat_d  = fsat_q;
    sh_d    = sh_q;
    sel_d   = sel_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    clear_d = clear_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          tmr_d   = '0;
          ch_d    = 2'd0;
          sel_d   = filter_sel(2'd0);
          cnt_d   = '0;
          fsat_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = GATE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GATE: begin
        // An edge arriving at full scale is the one that marks the frame saturated.
        if (edge_q) begin
          if (cnt_q == CNT_MAX) fsat_d = 1'b1;
          else                  cnt_d  = cnt_q + 1'b1;
        end
        if (tmr_q == GATE_LAST) begin
          state_d = STORE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      STORE: begin
        cnt_d = '0;
        case (ch_q)
          2'd0: sh_d[0] = cnt_q;
          2'd1: sh_d[1] = cnt_q;
          2'd2: sh_d[2] = cnt_q;
          default: ;
        endcase
        if (ch_q == 2'd3) begin
          // Publish on entry to DONE so the new frame is visible together with get_it.
          state_d = DONE;
          red_d   = sh_q[0];
          green_d = sh_q[1];
          blue_d  = sh_q[2];
          clear_d = cnt_q;
          sat_d   = fsat_q;
        end else begin
          state_d = SETTLE;
          ch_d    = ch_q + 2'd1;
          sel_d   = filter_sel(ch_q + 2'd1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      ch_q    <= 2'd0;
      cnt_q   <= '0;
      fsat_q  <= 1'b0;
      // NOTE: the shadow bank is reset too, so an aborted frame leaves nothing stale behind.
      sh_q    <= '0;
      sel_q   <= 2'b00;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      clear_q <= '0;
      sat_q   <= 1'b0;
      sync_q  <= 3'b000;
      edge_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      fsat_q  <= fsat_d;
      sh_q    <= sh_d;
      sel_q   <= sel_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      clear_q <= clear_d;
      sat_q   <= sat_d;
      sync_q  <= {sync_q[1:0], in_sq};
      edge_q  <= sync_q[1] & ~sync_q[2];
    end
  end

  assign s_ctrl = sel_q;
  assign get_it = (state_q == DONE);
  assign busy   = (state_q != IDLE);
  assign red    = red_q;
  assign green  = green_q;
  assign blue   = blue_q;
  assign clear  = clear_q;
  assign sat    = sat_q;

endmodule
